// File: rtl/hdmi_tmds_encoder_if.sv
// Pixel-side bundle for the TMDS encoder: video/control in, three 10-bit symbols out.
// HDMI_TERC4_EN adds the data-island flag and the three aux nibbles.
interface hdmi_tmds_encoder_if;
  logic       de;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       hsync;
  logic       vsync;
`ifdef HDMI_TERC4_EN
  logic       island;
  logic [3:0] aux_red;
  logic [3:0] aux_green;
  logic [3:0] aux_blue;
`endif
  logic [9:0] tmds_red;
  logic [9:0] tmds_green;
  logic [9:0] tmds_blue;

`ifdef HDMI_TERC4_EN
  modport master (output de, red, green, blue, hsync, vsync,
                  island, aux_red, aux_green, aux_blue,
                  input  tmds_red, tmds_green, tmds_blue);
  modport slave  (input  de, red, green, blue, hsync, vsync,
                  island, aux_red, aux_green, aux_blue,
                  output tmds_red, tmds_green, tmds_blue);
`else
  modport master (output de, red, green, blue, hsync, vsync,
                  input  tmds_red, tmds_green, tmds_blue);
  modport slave  (input  de, red, green, blue, hsync, vsync,
                  output tmds_red, tmds_green, tmds_blue);
`endif
endinterface

// File: rtl/hdmi_tmds_encoder.sv
// TMDS encoder for R/G/B, 2-cycle latency, inputs sampled every cycle (no backpressure).
// Define HDMI_TERC4_EN to add TERC4 data-island encoding from the aux nibbles.
module hdmi_tmds_encoder (
  input  logic               clk,
  input  logic               reset,
  hdmi_tmds_encoder_if.slave bus
);

  localparam logic [9:0] CTRL_00 = 10'h354;

  function automatic logic [8:0] qm_encode(input logic [7:0] d);
    logic [3:0] n1;
    logic       xnor_mode;
    logic [8:0] q;
    n1        = 4'($countones(d));
    xnor_mode = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    q         = '0;
    q[0]      = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = xnor_mode ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xnor_mode;
    return q;
  endfunction

  // Returns {next_cnt, symbol}; diff is ones-minus-zeros of q_m[7:0].
  function automatic logic [14:0] balance(input logic [8:0] q, input logic signed [4:0] cnt);
    logic [3:0]        n1;
    logic signed [4:0] diff;
    logic signed [4:0] nxt;
    logic [9:0]        sym;
    n1   = 4'($countones(q[7:0]));
    diff = $signed(5'({n1, 1'b0} - 5'd8));
    if (cnt == 5'sd0 || diff == 5'sd0) begin
      sym = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      nxt = q[8] ? (cnt + diff) : (cnt - diff);
    end else if ((cnt > 5'sd0 && diff > 5'sd0) || (cnt < 5'sd0 && diff < 5'sd0)) begin
      sym = {1'b1, q[8], ~q[7:0]};
      nxt = cnt + (q[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      sym = {1'b0, q[8], q[7:0]};
      nxt = cnt + diff - (q[8] ? 5'sd0 : 5'sd2);
    end
    return {nxt, sym};
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'h354;
      2'b01:   s = 10'h0AB;
      2'b10:   s = 10'h154;
      default: s = 10'h2AB;
    endcase
    return s;
  endfunction

`ifdef HDMI_TERC4_EN
  function automatic logic [9:0] terc4(input logic [3:0] n);
    logic [9:0] s;
    case (n)
      4'h0: s = 10'h29C;  4'h1: s = 10'h263;  4'h2: s = 10'h2E4;  4'h3: s = 10'h2E2;
      4'h4: s = 10'h171;  4'h5: s = 10'h11E;  4'h6: s = 10'h18E;  4'h7: s = 10'h13C;
      4'h8: s = 10'h2CC;  4'h9: s = 10'h139;  4'hA: s = 10'h19C;  4'hB: s = 10'h2C6;
      4'hC: s = 10'h28E;  4'hD: s = 10'h271;  4'hE: s = 10'h163;  default: s = 10'h2C3;
    endcase
    return s;
  endfunction

  logic       island_s1;
  logic [3:0] aux_red_s1, aux_green_s1, aux_blue_s1;
`endif

  logic              de_s1, hsync_s1, vsync_s1;
  logic [8:0]        qm_red, qm_green, qm_blue;
  logic signed [4:0] cnt_red, cnt_green, cnt_blue;
  logic [9:0]        sym_red, sym_green, sym_blue;
  logic [14:0]       bal_red, bal_green, bal_blue;

  assign bal_red   = balance(qm_red,   cnt_red);
  assign bal_green = balance(qm_green, cnt_green);
  assign bal_blue  = balance(qm_blue,  cnt_blue);

  always_ff @(posedge clk) begin
    if (reset) begin
      de_s1     <= 1'b0;
      hsync_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
      qm_red    <= '0;
      qm_green  <= '0;
      qm_blue   <= '0;
      cnt_red   <= '0;
      cnt_green <= '0;
      cnt_blue  <= '0;
      sym_red   <= CTRL_00;
      sym_green <= CTRL_00;
      sym_blue  <= CTRL_00;
`ifdef HDMI_TERC4_EN
      island_s1    <= 1'b0;
      aux_red_s1   <= '0;
      aux_green_s1 <= '0;
      aux_blue_s1  <= '0;
`endif
    end else begin
      de_s1    <= bus.de;
      hsync_s1 <= bus.hsync;
      vsync_s1 <= bus.vsync;
      qm_red   <= qm_encode(bus.red);
      qm_green <= qm_encode(bus.green);
      qm_blue  <= qm_encode(bus.blue);
`ifdef HDMI_TERC4_EN
      island_s1    <= bus.island;
      aux_red_s1   <= bus.aux_red;
      aux_green_s1 <= bus.aux_green;
      aux_blue_s1  <= bus.aux_blue;
`endif
      if (de_s1) begin
        {cnt_red,   sym_red}   <= bal_red;
        {cnt_green, sym_green} <= bal_green;
        {cnt_blue,  sym_blue}  <= bal_blue;
      end else begin
        // Any blanking symbol restarts DC balance for the next active pixel.
        cnt_red   <= '0;
        cnt_green <= '0;
        cnt_blue  <= '0;
`ifdef HDMI_TERC4_EN
        if (island_s1) begin
          sym_red   <= terc4(aux_red_s1);
          sym_green <= terc4(aux_green_s1);
          sym_blue  <= terc4(aux_blue_s1);
        end else begin
          sym_red   <= CTRL_00;
          sym_green <= CTRL_00;
          sym_blue  <= ctrl_sym({vsync_s1, hsync_s1});
        end
`else
        sym_red   <= CTRL_00;
        sym_green <= CTRL_00;
        sym_blue  <= ctrl_sym({vsync_s1, hsync_s1});
`endif
      end
    end
  end

  assign bus.tmds_red   = sym_red;
  assign bus.tmds_green = sym_green;
  assign bus.tmds_blue  = sym_blue;

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Scoreboard bench for hdmi_tmds_encoder: expected symbols queued at drive time, popped 2 cycles later.
module tb_hdmi_tmds_encoder;
  logic clk = 1'b0;
  logic reset;
  always #20 clk = ~clk;

  hdmi_tmds_encoder_if bus ();
  hdmi_tmds_encoder dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [2:0][9:0] sym;
    logic [2:0][7:0] px;
    bit              vid;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt_m[3];
  int   rd[3];

  logic [9:0] ctrl_tab[4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  logic [9:0] terc_tab[16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                               10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};
  string ch_name[3] = '{"red", "green", "blue"};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] enc(input int ch, input logic [7:0] d);
    logic [8:0] q;
    logic [9:0] s;
    int         n1, n0;
    bit         xn;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q  = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? !(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !xn;
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    if (cnt_m[ch] == 0 || n1 == n0) begin
      s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      cnt_m[ch] += q[8] ? (n1 - n0) : (n0 - n1);
    end else if ((cnt_m[ch] > 0 && n1 > n0) || (cnt_m[ch] < 0 && n0 > n1)) begin
      s = {1'b1, q[8], ~q[7:0]};
      cnt_m[ch] += (q[8] ? 2 : 0) + (n0 - n1);
    end else begin
      s = {1'b0, q[8], q[7:0]};
      cnt_m[ch] += (n1 - n0) - (q[8] ? 0 : 2);
    end
    return s;
  endfunction

  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : !(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic observe(input exp_t o);
    logic [9:0] got[3];
    got[0] = bus.tmds_red;
    got[1] = bus.tmds_green;
    got[2] = bus.tmds_blue;
    for (int k = 0; k < 3; k++) begin
      check({"sym_", ch_name[k]}, 32'(got[k]), 32'(o.sym[k]));
      if (o.vid) begin
        rd[k] += 2 * $countones(got[k]) - 10;
        check({"rd_bound_", ch_name[k]}, 32'(rd[k] >= -10 && rd[k] <= 10), 32'd1);
        check({"decode_", ch_name[k]}, 32'(dec(got[k])), 32'(o.px[k]));
      end else begin
        rd[k] = 0;
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic de_i, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic hs, input logic vs, input logic isl,
                       input logic [3:0] ar, input logic [3:0] ag, input logic [3:0] ab);
    exp_t e, blank;
    @(negedge clk);
    if (sbq.size() >= 2) observe(sbq.pop_front());
    reset     = rst;
    bus.de    = de_i;
    bus.red   = r;
    bus.green = g;
    bus.blue  = b;
    bus.hsync = hs;
    bus.vsync = vs;
`ifdef HDMI_TERC4_EN
    bus.island    = isl;
    bus.aux_red   = ar;
    bus.aux_green = ag;
    bus.aux_blue  = ab;
`endif
    blank.sym = {3{10'h354}};
    blank.px  = '0;
    blank.vid = 1'b0;
    e = blank;
    e.px = {b, g, r};
    if (rst) begin
      foreach (sbq[i]) sbq[i] = blank;
      for (int k = 0; k < 3; k++) cnt_m[k] = 0;
      e = blank;
    end else if (de_i) begin
      e.vid    = 1'b1;
      e.sym[0] = enc(0, r);
      e.sym[1] = enc(1, g);
      e.sym[2] = enc(2, b);
    end else begin
      for (int k = 0; k < 3; k++) cnt_m[k] = 0;
`ifdef HDMI_TERC4_EN
      if (isl) begin
        e.sym[0] = terc_tab[ar];
        e.sym[1] = terc_tab[ag];
        e.sym[2] = terc_tab[ab];
      end else begin
        e.sym[0] = 10'h354;
        e.sym[1] = 10'h354;
        e.sym[2] = ctrl_tab[{vs, hs}];
      end
`else
      e.sym[0] = 10'h354;
      e.sym[1] = 10'h354;
      e.sym[2] = ctrl_tab[{vs, hs}];
`endif
    end
    sbq.push_back(e);
  endtask

  task automatic vid(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    cycle(1'b0, 1'b1, r, g, b, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic ctl(input logic hs, input logic vs);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, hs, vs, 1'b0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic rst_cyc();
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic rnd_vid();
    vid(8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    reset     = 1'b1;
    bus.de    = 1'b0;
    bus.red   = '0;
    bus.green = '0;
    bus.blue  = '0;
    bus.hsync = 1'b0;
    bus.vsync = 1'b0;
`ifdef HDMI_TERC4_EN
    bus.island    = 1'b0;
    bus.aux_red   = '0;
    bus.aux_green = '0;
    bus.aux_blue  = '0;
`endif
    for (int k = 0; k < 3; k++) begin
      cnt_m[k] = 0;
      rd[k]    = 0;
    end

    // Reset for 3 cycles, then idle blanking.
    repeat (3) rst_cyc();
    repeat (3) ctl(1'b0, 1'b0);

    // Control symbols on the blue channel.
    repeat (2) ctl(1'b1, 1'b0);
    repeat (2) ctl(1'b1, 1'b1);
    repeat (2) ctl(1'b0, 1'b1);
    ctl(1'b0, 1'b0);

    // All-zero pixels from cnt=0: blue walks 0x100, 0x3FF, 0x100.
    repeat (3) vid(8'h00, 8'h00, 8'h00);
    ctl(1'b0, 1'b0);
    repeat (4) vid(8'hFF, 8'h0F, 8'hF0);

    // de toggling every cycle.
    for (int i = 0; i < 20; i++) begin
      rnd_vid();
      ctl(i[0], i[1]);
    end

    // Reset pulsed in the middle of an active line.
    repeat (6) rnd_vid();
    rst_cyc();
    repeat (6) rnd_vid();
    repeat (5) rnd_vid();
    rst_cyc();
    rst_cyc();
    repeat (4) rnd_vid();

`ifdef HDMI_TERC4_EN
    ctl(1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4'h3, 4'hA, 4'h5);
    for (int i = 0; i < 16; i++)
      cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 4'(i), 4'(15 - i), 4'(i + 5));
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b1, 4'h5, 4'h5, 4'h5);
    ctl(1'b1, 1'b0);
`endif

    // 10k random pixels with occasional blanking and extreme values.
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 15))
        0:       ctl(1'($urandom), 1'($urandom));
        1:       vid(8'h00, 8'hFF, 8'($urandom));
        2:       vid(8'hFF, 8'h00, 8'hAA);
        default: rnd_vid();
      endcase
    end

    ctl(1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      if (sbq.size() > 0) observe(sbq.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hdmi_tmds_encoder.md
HDMI_TMDS_ENCODER -- requirements
Module: hdmi_tmds_encoder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 clk  in  1  pixel clock (25 MHz); the 250 MHz serializer clock is generated upstream by the PLL.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 de  in  1  data enable; 1 = active video.
REQ-005 red, green, blue  in  8 each  pixel colour components.
REQ-006 hsync, vsync  in  1 each  sync control bits.
REQ-007 tmds_red, tmds_green, tmds_blue  out  10 each  registered TMDS symbols; bit 0 is transmitted first.

Function
REQ-008 Inputs SHALL be sampled every cycle; symbols SHALL appear exactly 2 cycles later (stage 1: q_m; stage 2: DC balance and output register).
REQ-009 Channel control pairs {c1,c0}: blue={vsync,hsync}; green=00; red=00.
REQ-010 Stage 1: n1=popcount(d); XNOR mode if n1>4, or n1==4 with d[0]==0, else XOR mode; q_m[0]=d[0]; q_m[i]=q_m[i-1] XOR/XNOR d[i]; q_m[8]=1 for XOR, 0 for XNOR.
REQ-011 Each channel SHALL hold a 5-bit signed disparity counter cnt; N1/N0 = ones/zeros of q_m[7:0].
REQ-012 If cnt==0 or N1==N0: out={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}; cnt += q_m[8]?(N1-N0):(N0-N1).
REQ-013 Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out={1,q_m[8],~q_m[7:0]}; cnt += 2*q_m[8]+(N0-N1).
REQ-014 Otherwise: out={0,q_m[8],q_m[7:0]}; cnt += (N1-N0)-2*(~q_m[8]).
REQ-015 When de=0 (stage-2 view): control symbols 00->0x354, 01->0x0AB, 10->0x154, 11->0x2AB; cnt SHALL be cleared to 0.
REQ-016 de and control bits SHALL be pipelined alongside q_m so both stages refer to the same input cycle.
REQ-017 de toggling on consecutive cycles SHALL be legal; the first active pixel after blanking SHALL start from cnt=0.

Reset
REQ-018 During reset, all three outputs SHALL be 0x354, all cnt registers SHALL be 0, and pipeline de registers SHALL be 0.
REQ-019 Reset asserted mid-line SHALL take effect on the next edge; valid encoding SHALL resume 2 cycles after deassertion.

Configuration
REQ-020 Macro HDMI_TERC4_EN SHALL add inputs island (1) and aux_red, aux_green, aux_blue (4 each).
REQ-021 With HDMI_TERC4_EN, when de=0 and island=1, each channel SHALL output TERC4(aux nibble) with 2-cycle latency, and cnt SHALL be cleared. TERC4 0..F: 0x29C,0x263,0x2E4,0x2E2,0x171,0x11E,0x18E,0x13C,0x2CC,0x139,0x19C,0x2C6,0x28E,0x271,0x163,0x2C3.
REQ-022 Priority with HDMI_TERC4_EN: de=1 video > island > control.
REQ-023 Without HDMI_TERC4_EN, the island and aux ports SHALL be absent and behaviour SHALL follow REQ-008..REQ-019 only.

Verification
REQ-024 Reset held 3 cycles -> all outputs 0x354 during reset and for 2 cycles after release with de=0, hsync=vsync=0.
REQ-025 de=0, hsync=1, vsync=0 -> tmds_blue=0x0AB; green and red=0x354 after 2 cycles; vsync=1, hsync=1 -> blue 0x2AB.
REQ-026 de=1, blue=0x00 for 3 cycles from cnt=0 -> tmds_blue 0x100, 0x3FF, 0x100; cnt -8, 2, -6.
REQ-027 Random video of 10k pixels vs. reference model -> bit-exact symbols; |cnt| never exceeds 10; decode of each symbol returns the input byte.
REQ-028 Reset pulsed mid-active line -> output 0x354 next cycle; first pixel after release encoded with cnt=0.
REQ-029 With HDMI_TERC4_EN: de=0, island=1, aux_blue=0x5 -> tmds_blue=0x11E after 2 cycles; de=1 with island=1 -> video symbols.
